// File: rtl/sm_muldiv_pkg.sv
// Shared encodings and defaults for the iterative MULTU/DIVU sequencer.
package sm_muldiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

endpackage

// File: rtl/sm_muldiv_if.sv
// Core-side bundle of the multiply/divide sequencer: request, stall, results, FSM debug.
import sm_muldiv_pkg::*;

interface sm_muldiv_if #(parameter int WIDTH = WIDTH_DEFAULT);

    // start is a one-sided request: it is taken in the cycle the sequencer is idle
    // with a valid op, and stall rises in that same cycle; no ready/ack exists.
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             divZero;
    logic [0:0]       dbg_state;

    modport master (
        output start, op, srcA, srcB,
        input  stall, done, hi, lo, divZero, dbg_state
    );

    modport slave (
        input  start, op, srcA, srcB,
        output stall, done, hi, lo, divZero, dbg_state
    );

endinterface

// File: rtl/sm_muldiv_step.sv
// One radix-2 iteration: shift-add for MULTU, restoring subtract for DIVU.
import sm_muldiv_pkg::*;

module sm_muldiv_step #(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_mq,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_mq
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;
    logic           w_borrow;

    assign w_sum    = {1'b0, i_acc} + (i_mq[0] ? {1'b0, i_operand} : '0);
    assign w_rem_sh = {i_acc, i_mq[WIDTH-1]};
    // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
    assign w_diff   = w_rem_sh - {1'b0, i_operand};
    assign w_borrow = w_diff[WIDTH];

    always_comb begin
        o_acc = '0;
        o_mq  = '0;
        if (i_op == OP_DIVU) begin
            o_acc = w_borrow ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
            o_mq  = {i_mq[WIDTH-2:0], ~w_borrow};
        end else begin
            o_acc = w_sum[WIDTH:1];
            o_mq  = {w_sum[0], i_mq[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sm_muldiv_seq.sv
// Iterative unsigned MULTU/DIVU sequencer: stalls the core for WIDTH+1 cycles, writes HI/LO.
import sm_muldiv_pkg::*;

module sm_muldiv_seq #(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input logic        clk,
    input logic        rst_n,
    sm_muldiv_if.slave bus
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mq;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_div_zero;

    logic             w_op_valid;
    logic             w_accept;
    logic [WIDTH-1:0] w_next_acc;
    logic [WIDTH-1:0] w_next_mq;

    assign w_op_valid = (bus.op == OP_MULTU) || (bus.op == OP_DIVU);
    assign w_accept   = (r_state == S_IDLE) && bus.start && w_op_valid;

    sm_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_op      (r_op),
        .i_acc     (r_acc),
        .i_mq      (r_mq),
        .i_operand (r_operand),
        .o_acc     (w_next_acc),
        .o_mq      (w_next_mq)
    );

    // r_mq carries the multiplier for MULTU and the dividend/quotient for DIVU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op       <= OP_MULTU;
            r_acc      <= '0;
            r_mq       <= '0;
            r_operand  <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    r_state    <= S_RUN;
                    r_cnt      <= '0;
                    r_op       <= bus.op;
                    r_acc      <= '0;
                    r_mq       <= (bus.op == OP_DIVU) ? bus.srcA : bus.srcB;
                    r_operand  <= (bus.op == OP_DIVU) ? bus.srcB : bus.srcA;
                    r_div_zero <= (bus.op == OP_DIVU) && (bus.srcB == '0);
                end
            end else begin
                r_acc <= w_next_acc;
                r_mq  <= w_next_mq;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    r_state <= S_IDLE;
                    r_hi    <= w_next_acc;
                    r_lo    <= w_next_mq;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign bus.stall     = (r_state == S_RUN) || w_accept;
    assign bus.done      = r_done;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.divZero   = r_div_zero;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_sm_muldiv_seq.sv
// Self-checking bench for sm_muldiv_seq: directed table, corner sequences, random ops vs. arithmetic model.
import sm_muldiv_pkg::*;

module tb_sm_muldiv_seq;

    localparam int W       = 32;
    localparam int LATENCY = W + 1;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic         exp_dz;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    logic [2*W:0] exp_q[$];

    sm_muldiv_if #(.WIDTH(W)) bus ();

    sm_muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Returns {divZero, hi, lo} from plain arithmetic.
    function automatic logic [2*W:0] ref_model(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        logic [2*W-1:0] p;
        if (op == OP_MULTU) begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            return {1'b0, p};
        end
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        return {1'b0, a % b, a / b};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge: presents a valid request, checks the same-cycle stall,
    // lets the accepting edge pass and drops start on the following negedge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.srcA  = a;
        bus.srcB  = b;
        exp_q.push_back(ref_model(op, a, b));
        #1;
        check("issue_stall", W'(bus.stall), W'(1));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts stalled cycles (issue cycle included) until stall drops, then scores results.
    task automatic wait_done(input bit noise);
        int          cycles;
        int          early_done;
        logic [2*W:0] exp;
        cycles     = 1;
        early_done = 0;
        while (bus.stall && cycles < 200) begin
            if (bus.done) early_done++;
            if (noise && cycles < LATENCY - 2) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.op    = 2'($urandom_range(0, 3));
                bus.srcA  = $urandom;
                bus.srcB  = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            cycles++;
            @(negedge clk);
        end
        check("stall_cycles", W'(cycles), W'(LATENCY));
        check("early_done", W'(early_done), W'(0));
        check("done_pulse", W'(bus.done), W'(1));
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got a result, expected queue empty");
        end else begin
            exp = exp_q.pop_front();
            check("hi", bus.hi, exp[2*W-1:W]);
            check("lo", bus.lo, exp[W-1:0]);
            check("divZero", W'(bus.divZero), W'(exp[2*W]));
        end
    endtask

    // ---------------- test ----------------
    vec_t vecs[8];

    initial begin
        logic [W-1:0] save_hi;
        logic [W-1:0] save_lo;
        int           done_cnt;
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        n_vec = 0;
        n_err = 0;

        vecs[0] = '{OP_MULTU, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A, 1'b0};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[3] = '{OP_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{OP_MULTU, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0};
        vecs[5] = '{OP_DIVU,  32'd5,         32'd9,         32'd5,         32'd0,         1'b0};
        vecs[6] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{OP_MULTU, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 32'h0000_0000, 1'b0};

        bus.start = 1'b0;
        bus.op    = OP_MULTU;
        bus.srcA  = '0;
        bus.srcB  = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_hi", bus.hi, '0);
        check("rst_lo", bus.lo, '0);
        check("rst_done", W'(bus.done), W'(0));
        check("rst_stall", W'(bus.stall), W'(0));
        check("rst_divZero", W'(bus.divZero), W'(0));
        check("rst_state", W'(bus.dbg_state), W'(S_IDLE));

        // Directed table: the model must agree with the hand-written expectations too.
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            exp_q[exp_q.size()-1] = {vecs[i].exp_dz, vecs[i].exp_hi, vecs[i].exp_lo};
            wait_done(1'b0);
            check("tbl_model_hi", ref_model(vecs[i].op, vecs[i].a, vecs[i].b) >> W, W'(vecs[i].exp_hi));
            @(negedge clk);
        end

        // Reset in the middle of a MULTU discards the result.
        issue(OP_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_hi", bus.hi, '0);
        check("midrst_lo", bus.lo, '0);
        check("midrst_stall", W'(bus.stall), W'(0));
        check("midrst_done", W'(bus.done), W'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("midrst_no_done", W'(done_cnt), W'(0));

        // Reserved opcodes are ignored: no stall, no state change, HI/LO hold.
        issue(OP_MULTU, 32'd2, 32'd3);
        wait_done(1'b0);
        @(negedge clk);
        for (int k = 2; k < 4; k++) begin
            bus.start = 1'b1;
            bus.op    = 2'(k);
            bus.srcA  = 32'hAAAA_AAAA;
            bus.srcB  = 32'h5555_5555;
            #1;
            check("rsv_stall", W'(bus.stall), W'(0));
            @(negedge clk);
            check("rsv_state", W'(bus.dbg_state), W'(S_IDLE));
            check("rsv_lo_hold", bus.lo, 32'd6);
        end
        bus.start = 1'b0;
        @(negedge clk);

        // Back-to-back: a DIVU issued in the done cycle, with start noise during RUN.
        issue(OP_MULTU, 32'd123, 32'd456);
        wait_done(1'b1);
        issue(OP_DIVU, 32'd1000, 32'd33);
        wait_done(1'b1);
        save_hi = bus.hi;
        save_lo = bus.lo;
        @(negedge clk);
        check("hold_hi", bus.hi, save_hi);
        check("hold_lo", bus.lo, save_lo);
        check("done_one_cycle", W'(bus.done), W'(0));

        // Randomized ops against the arithmetic model, some chained back-to-back.
        for (int r = 0; r < 24; r++) begin
            rop = 2'($urandom_range(0, 1));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            issue(rop, ra, rb);
            wait_done(r[0]);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

endmodule
